// File: rtl/traceback_unit.sv
// Viterbi traceback: walks the survivor path backwards from a start state, buffers one
// decoded bit per stage, then replays the bits oldest-first over a valid/ready handshake.
module traceback_unit #(
  parameter int unsigned STATE_W   = 8,
  parameter int unsigned STATE_NUM = 256,
  parameter int unsigned TB_DEPTH  = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_t,
  input  logic               i_start,
  input  logic [STATE_W-1:0] i_start_st,
  input  logic               i_bck_vld,
  input  logic [STATE_W-1:0] i_bck_prv_st [STATE_NUM],
  output logic               o_bit,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_ovf
);

  localparam int unsigned      IdxW    = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TB_DEPTH - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StTrace = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [STATE_W-1:0]  cur_st_q, cur_st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bit_q, bit_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic [TB_DEPTH-1:0] bits_q;
  logic                wr_en;
  logic                done;
  logic                msb;
  logic [IdxW-1:0]     wr_idx;
  logic [IdxW-1:0]     rd_idx;

  assign msb    = cur_st_q[STATE_W-1];
  assign wr_idx = cnt_q[IdxW-1:0];
  // Bit to present after accepting buf[cnt-1] is buf[cnt-2].
  assign rd_idx = IdxW'(cnt_q - CNT_W'(2));

  always_comb begin
    state_d  = state_q;
    cur_st_d = cur_st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    done     = 1'b0;
    if (en_t) begin
      case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d  = StTrace;
            cur_st_d = i_start_st;
            cnt_d    = '0;
          end
        end
        StTrace: begin
          if (i_start) ovf_d = 1'b1;
          if (i_bck_vld) begin
            wr_en    = 1'b1;
            cur_st_d = i_bck_prv_st[cur_st_q];
            cnt_d    = cnt_q + CntOne;
            if (cnt_q == CntLast) begin
              // Newest captured bit is the first one replayed, so forward it directly.
              state_d = StEmit;
              valid_d = 1'b1;
              bit_d   = msb;
            end
          end
        end
        StEmit: begin
          if (i_start || i_bck_vld) ovf_d = 1'b1;
          if (valid_q && i_ready) begin
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
              done    = 1'b1;
              valid_d = 1'b0;
              state_d = StIdle;
            end else begin
              bit_d = bits_q[rd_idx];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cur_st_q <= '0;
      cnt_q    <= '0;
      bit_q    <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_st_q <= cur_st_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) bits_q[wr_idx] <= msb;
  end

  assign o_bit   = bit_q;
  assign o_valid = valid_q;
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done & rst;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Randomized scoreboard bench for traceback_unit: a path-walking model queues expected bits,
// and an independent monitor checks every accepted output bit.
module tb_traceback_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_t;
  logic       i_start;
  logic [7:0] i_start_st;
  logic       i_bck_vld;
  logic [7:0] prv [256];
  logic       o_bit;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_ovf;

  always #5 clk = ~clk;

  traceback_unit #(
    .STATE_W  (8),
    .STATE_NUM(256),
    .TB_DEPTH (64),
    .CNT_W    (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_t        (en_t),
    .i_start     (i_start),
    .i_start_st  (i_start_st),
    .i_bck_vld   (i_bck_vld),
    .i_bck_prv_st(prv),
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_ovf       (o_ovf)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed handshake.
  logic pv = 1'b0, pb = 1'b0, pacc = 1'b0, prst = 1'b0;
  initial begin : monitor
    exp_t e;
    logic acc;
    forever begin
      @(negedge clk);
      if (rst && prst && pv && !pacc) begin
        chk("stall_valid", {31'd0, o_valid}, 32'd1);
        chk("stall_bit", {31'd0, o_bit}, {31'd0, pb});
      end
      acc = o_valid && i_ready && en_t;
      if (rst) begin
        if (acc) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got %0b expected no output", o_bit);
          end else begin
            e = sb.pop_front();
            chk("bit", {31'd0, o_bit}, {31'd0, e.b});
            chk("done", {31'd0, o_done}, {31'd0, e.last});
            chk("busy_at_accept", {31'd0, o_busy}, 32'd1);
          end
          if (o_done) done_cnt++;
          acc_cnt++;
        end else begin
          chk("done_no_accept", {31'd0, o_done}, 32'd0);
        end
      end
      pv   = o_valid;
      pb   = o_bit;
      pacc = rst && acc;
      prst = rst;
    end
  end

  task automatic fill(input int mode);
    logic [7:0] sv;
    for (int s = 0; s < 256; s++) begin
      sv = 8'(s);
      case (mode)
        0:       prv[s] = 8'h00;
        1:       prv[s] = sv;
        2:       prv[s] = {sv[6:0], sv[7]};
        default: prv[s] = 8'($urandom);
      endcase
    end
  endtask

  // Drives one block and models it: the decoded bit of each stage is the MSB of the state
  // on the survivor path; bits come back out in reverse capture order.
  task automatic run_block(input logic [7:0] start, input int mode, input int gaps,
                           input int stall, input int misuse, input int enrnd,
                           input int abort_after);
    logic [7:0] cur;
    logic       cap [64];
    exp_t       e;
    int         base;
    int         d0;
    int         n;
    d0 = done_cnt;
    @(posedge clk); #1;
    en_t       = 1'b1;
    i_ready    = 1'b1;
    i_start    = 1'b1;
    i_start_st = start;
    i_bck_vld  = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    chk("valid_in_trace", {31'd0, o_valid}, 32'd0);
    cur = start;
    for (int k = 0; k < 64; k++) begin
      while (gaps != 0 && $urandom_range(0, 3) == 0) begin
        fill(3);
        if (enrnd != 0 && $urandom_range(0, 1) == 1) begin
          en_t      = 1'b0;
          i_bck_vld = 1'b1;
        end else begin
          en_t      = 1'b1;
          i_bck_vld = 1'b0;
        end
        i_start = 1'b0;
        @(posedge clk); #1;
      end
      en_t = 1'b1;
      fill(mode);
      i_bck_vld = 1'b1;
      i_start   = (misuse != 0 && k == 20);
      cap[k]    = cur[7];
      cur       = prv[cur];
      if (k == 63) begin
        for (int j = 63; j >= 0; j--) begin
          e.b    = cap[j];
          e.last = (j == 0);
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    i_bck_vld = 1'b0;
    i_start   = 1'b0;
    base      = acc_cnt;
    for (n = 0; n < 2000 && done_cnt == d0; n++) begin
      if (abort_after > 0 && acc_cnt - base == abort_after) break;
      i_ready = (n < stall) ? 1'b0 : ((gaps != 0) ? ($urandom_range(0, 2) != 0) : 1'b1);
      en_t    = (enrnd != 0) ? ($urandom_range(0, 4) != 0) : 1'b1;
      if (misuse != 0 && n == 3) begin
        fill(3);
        i_bck_vld = 1'b1;
        i_start   = 1'b1;
      end else begin
        i_bck_vld = 1'b0;
        i_start   = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_bck_vld = 1'b0;
    i_start   = 1'b0;
    en_t      = 1'b1;
    i_ready   = 1'b1;
    if (abort_after > 0) begin
      chk("accepted_before_abort", acc_cnt - base, abort_after);
    end else if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL block_timeout: got %0d accepted bits expected 64", acc_cnt - base);
    end else begin
      chk("busy_after_done", {31'd0, o_busy}, 32'd0);
      chk("valid_after_done", {31'd0, o_valid}, 32'd0);
      chk("accepted_bits", acc_cnt - base, 32'd64);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_bit"}, {31'd0, o_bit}, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, o_ovf}, 32'd0);
  endtask

  initial begin : main
    rst        = 1'b0;
    en_t       = 1'b1;
    i_start    = 1'b0;
    i_start_st = 8'h00;
    i_bck_vld  = 1'b0;
    i_ready    = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b1;

    // Stage data in IDLE is ignored and not an overflow.
    fill(3);
    i_bck_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_bck_vld = 1'b0;
    chk("idle_vld_busy", {31'd0, o_busy}, 32'd0);
    chk("idle_vld_ovf", {31'd0, o_ovf}, 32'd0);

    run_block(8'h80, 0, 0, 0, 0, 0, 0);
    chk("ovf_clean_zero_ptr", {31'd0, o_ovf}, 32'd0);
    run_block(8'hFF, 1, 0, 0, 0, 0, 0);
    run_block(8'h01, 2, 0, 0, 0, 0, 0);
    run_block(8'($urandom), 3, 1, 5, 0, 1, 0);
    chk("ovf_clean_backpressure", {31'd0, o_ovf}, 32'd0);
    repeat (3) run_block(8'($urandom), 3, 1, 0, 0, 1, 0);

    run_block(8'($urandom), 3, 0, 0, 1, 0, 0);
    chk("ovf_after_misuse", {31'd0, o_ovf}, 32'd1);
    run_block(8'($urandom), 3, 1, 0, 0, 0, 0);
    chk("ovf_sticky", {31'd0, o_ovf}, 32'd1);

    run_block(8'($urandom), 3, 0, 0, 0, 0, 10);
    rst     = 1'b0;
    i_ready = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("mid_emit_reset");
    sb.delete();
    rst     = 1'b1;
    i_ready = 1'b1;

    run_block(8'($urandom), 3, 1, 2, 0, 1, 0);
    chk("ovf_after_fresh_block", {31'd0, o_ovf}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Consumer end of the survivor-path memory in the Viterbi decoder.
- Takes the backward stream of per-stage previous-state tables, which arrive newest stage first, and walks the survivor path from a chosen start state.
- Extracts one decoded bit per stage into a LIFO bit buffer.
- Replays the decoded bits oldest-first to the downstream sink over a valid/ready handshake.

Parameters:
- STATE_W, 8: width of a state index; equals `MAX_STATE_REG_NUM.
- STATE_NUM, 256: number of trellis states; equals `MAX_STATE_NUM = 2**STATE_W.
- TB_DEPTH, 64: stages per traceback block; equals `TRACEBACK_DEPTH.
- CNT_W, 7: counter width; must satisfy 2**CNT_W > TB_DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low.
- en_t  input  1  block enable; when 0 all state holds and no handshake advances.
- i_start  input  1  one-cycle pulse; begins a traceback block.
- i_start_st  input  STATE_W  start state, normally the best-metric state; sampled with i_start.
- i_bck_vld  input  1  qualifies i_bck_prv_st as one stage, newest stage first.
- i_bck_prv_st  input  STATE_W x STATE_NUM (unpacked)  previous-state pointer for every state at the current stage.
- o_bit  output  1  decoded bit, oldest first.
- o_valid  output  1  o_bit is valid.
- i_ready  input  1  sink accepts o_bit when o_valid && i_ready.
- o_busy  output  1  high in TRACE or EMIT.
- o_done  output  1  one-cycle pulse on acceptance of the final bit.
- o_ovf  output  1  sticky flag: stage data or a start arrived while busy.

Behaviour:
- Reset (rst==0 at a clk edge), from any state including mid-block:
  - FSM goes to IDLE; cur_st=0, cnt=0, buffer contents don't-care.
  - All outputs 0: o_bit, o_valid, o_busy, o_done, o_ovf.
- Decoded-bit rule: bit = cur_st[STATE_W-1], the MSB of the current state. Trellis convention is next = {in, prev[STATE_W-1:1]}.
- FSM states: IDLE, TRACE, EMIT. Transitions below occur only when en_t==1.
- IDLE:
  - On i_start: cur_st <= i_start_st, cnt <= 0, go to TRACE.
  - i_bck_vld in IDLE is ignored and does not set o_ovf.
- TRACE:
  - Each cycle with i_bck_vld: buf[cnt] <= cur_st[MSB]; cur_st <= i_bck_prv_st[cur_st]; cnt <= cnt+1.
  - When the write at cnt==TB_DEPTH-1 occurs, go to EMIT next cycle with cnt <= TB_DEPTH.
  - Cycles without i_bck_vld hold all state (gaps allowed).
  - i_start in TRACE sets o_ovf and is otherwise ignored.
- EMIT:
  - o_valid=1 and o_bit=buf[cnt-1], registered so it is stable while o_valid && !i_ready.
  - On each accepted handshake, cnt decrements.
  - On acceptance at cnt==1: o_done pulses in that same cycle. Next cycle o_valid=0, FSM returns to IDLE.
  - i_bck_vld or i_start in EMIT sets o_ovf; data is dropped and the buffer is unaffected.
- First o_valid asserts the cycle after the final TRACE stage is captured.
- Minimum block time is TB_DEPTH stage cycles + TB_DEPTH emit cycles + 1.
- o_busy = (state != IDLE).
- o_ovf clears only on reset.
- i_start in the same cycle as the acceptance of the final bit is not accepted, because the FSM is still in EMIT. Upstream must re-issue it once o_busy==0.
- en_t==0 freezes the FSM, counters, and o_valid/o_bit; the handshake does not complete while en_t==0.
- Indexing i_bck_prv_st[cur_st] is a STATE_NUM:1 mux and may be registered internally only if the per-stage throughput of 1 stage/cycle is preserved.
- Arithmetic:
  - cnt is CNT_W bits unsigned and never wraps in legal operation.
  - Bits are emitted in the reverse of capture order, so chronological order is restored.

Test Plan:
- Reset, then i_start with i_start_st=8'h80, followed by 64 consecutive i_bck_vld stages with all pointers = 0, and i_ready=1 -> emitted bits are 63 zeros then a final 1. o_done pulses with the final 1, o_ovf=0.
- i_start_st=8'hFF, pointers prv[s]=s for all s -> 64 ones emitted. o_busy is high from the cycle after i_start through the o_done cycle.
- i_start_st=8'h01, pointers prv[s]={s[6:0],s[7]} (rotate-left) -> captured MSB sequence 0,0,0,0,0,0,0,1 repeating. Emitted sequence is its reverse; check all 64 bits.
- Backpressure: during EMIT, hold i_ready=0 for 5 cycles, plus random gaps in i_bck_vld during TRACE -> o_bit is stable while stalled, no bit is lost or duplicated, and exactly 64 bits are accepted.
- Misuse: pulse i_start during TRACE and drive i_bck_vld during EMIT -> o_ovf=1 and stays 1. The current block output is unchanged from the clean run.
- Reset mid-EMIT after 10 bits are accepted -> next cycle all outputs are 0 and state is IDLE. A fresh block then runs correctly, with o_ovf=0.
